// File: rtl/metric_memory.sv
// rtl/metric_memory.sv - ping-pong path-metric store with self-initialisation
// Optional build macro MM_REG_READ_EN registers the read port (latency 1).
module metric_memory (
  input  logic        Clock2,
  input  logic        Reset,
  input  logic        Restart,
  input  logic        MMWriteEnable,
  input  logic [3:0]  MMWriteAddress,
  input  logic [47:0] MMMetric,
  input  logic [2:0]  MMReadAddress,
  input  logic        MMBlockSelect,
  output logic [95:0] MMPathMetric,
  output logic        MMReady
);

  typedef enum logic {INIT, RUN} mmState_t;

  mmState_t    state, stateNext;
  logic [3:0]  initCount, initCountNext;
  logic        initWrite, runWrite;
  logic [47:0] initWord;
  logic [47:0] bank0 [16];
  logic [47:0] bank1 [16];
  logic [3:0]  readLo, readHi;
  logic [95:0] readPair;

  always_ff @(posedge Clock2 or negedge Reset) begin
    if (!Reset) begin
      state     <= INIT;
      initCount <= 4'd0;
    end else begin
      state     <= stateNext;
      initCount <= initCountNext;
    end
  end

  // ACS writes are only honoured in RUN; Restart in RUN suppresses the write.
  always_comb begin
    stateNext     = state;
    initCountNext = initCount;
    initWrite     = 1'b0;
    runWrite      = 1'b0;
    case (state)
      INIT: begin
        initWrite     = 1'b1;
        initCountNext = initCount + 4'd1;
        if (Restart)
          initCountNext = 4'd0;
        else if (initCount == 4'd15)
          stateNext = RUN;
      end
      RUN: begin
        if (Restart) begin
          stateNext     = INIT;
          initCountNext = 4'd0;
        end else begin
          runWrite = MMWriteEnable;
        end
      end
      default: stateNext = INIT;
    endcase
  end

  // State 0 starts at zero metric, every other state at the 0x200 bias.
  assign initWord = (initCount == 4'd0) ? 48'h200_200_200_000 : 48'h200_200_200_200;

  always_ff @(posedge Clock2 or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 16; i++) begin
        bank0[i] <= 48'd0;
        bank1[i] <= 48'd0;
      end
    end else if (initWrite) begin
      bank0[initCount] <= initWord;
      bank1[initCount] <= initWord;
    end else if (runWrite) begin
      if (MMBlockSelect)
        bank0[MMWriteAddress] <= MMMetric;
      else
        bank1[MMWriteAddress] <= MMMetric;
    end
  end

  assign readLo   = {MMReadAddress, 1'b0};
  assign readHi   = {MMReadAddress, 1'b1};
  assign readPair = MMBlockSelect ? {bank1[readHi], bank1[readLo]}
                                  : {bank0[readHi], bank0[readLo]};

`ifdef MM_REG_READ_EN
  always_ff @(posedge Clock2 or negedge Reset) begin
    if (!Reset)
      MMPathMetric <= 96'd0;
    else
      MMPathMetric <= readPair;
  end
`else
  assign MMPathMetric = readPair;
`endif

  assign MMReady = (state == RUN);

endmodule

// File: tb/tb_metric_memory.sv
// tb/tb_metric_memory.sv - directed bench for metric_memory
// Read checks wait one extra edge when built with MM_REG_READ_EN.
module tb_metric_memory;

  logic        Clock2;
  logic        Reset;
  logic        Restart;
  logic        MMWriteEnable;
  logic [3:0]  MMWriteAddress;
  logic [47:0] MMMetric;
  logic [2:0]  MMReadAddress;
  logic        MMBlockSelect;
  logic [95:0] MMPathMetric;
  logic        MMReady;

  int passCount;
  int checkCount;

  localparam logic [47:0] INIT_W0 = 48'h200_200_200_000;
  localparam logic [47:0] INIT_WN = 48'h200_200_200_200;

  metric_memory dut (
    .Clock2         (Clock2),
    .Reset          (Reset),
    .Restart        (Restart),
    .MMWriteEnable  (MMWriteEnable),
    .MMWriteAddress (MMWriteAddress),
    .MMMetric       (MMMetric),
    .MMReadAddress  (MMReadAddress),
    .MMBlockSelect  (MMBlockSelect),
    .MMPathMetric   (MMPathMetric),
    .MMReady        (MMReady)
  );

  initial Clock2 = 1'b0;
  always #5 Clock2 = ~Clock2;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [47:0] pattern(input int a);
    pattern = {12'(a * 4 + 3), 12'(a * 4 + 2), 12'(a * 4 + 1), 12'(a * 4)} ^ 48'hA50_A50_A50_A50;
  endfunction

  task automatic settleRead;
`ifdef MM_REG_READ_EN
    @(posedge Clock2);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    #1;
    checkCount++;
    if (MMPathMetric !== 96'd0) $display("FAIL reset_path: got %h expected 0", MMPathMetric);
    else passCount++;
    checkCount++;
    if (MMReady !== 1'b0) $display("FAIL reset_ready: got %b expected 0", MMReady);
    else passCount++;
    @(negedge Clock2);
    Reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkCount++;
      if (MMReady !== 1'b0) $display("FAIL init_ready_low edge %0d: got %b expected 0", i, MMReady);
      else passCount++;
      @(posedge Clock2);
      #1;
    end
    checkCount++;
    if (MMReady !== 1'b1) $display("FAIL init_ready_high: got %b expected 1", MMReady);
    else passCount++;
    @(negedge Clock2);
    MMBlockSelect = 1'b0;
    MMReadAddress = 3'd0;
    settleRead;
    checkCount++;
    if (MMPathMetric !== {INIT_WN, INIT_W0}) $display("FAIL init_pair0: got %h expected %h", MMPathMetric, {INIT_WN, INIT_W0});
    else passCount++;
    @(negedge Clock2);
    MMBlockSelect = 1'b1;
    MMReadAddress = 3'd7;
    settleRead;
    checkCount++;
    if (MMPathMetric !== {INIT_WN, INIT_WN}) $display("FAIL init_pair7_bank1: got %h expected %h", MMPathMetric, {INIT_WN, INIT_WN});
    else passCount++;
  endtask

  task automatic test_pingpong;
    @(negedge Clock2);
    MMBlockSelect  = 1'b0;
    MMWriteEnable  = 1'b1;
    MMWriteAddress = 4'd5;
    MMMetric       = 48'h123_456_789_ABC;
    @(negedge Clock2);
    MMWriteEnable  = 1'b0;
    MMReadAddress  = 3'd2;
    settleRead;
    checkCount++;
    if (MMPathMetric !== {INIT_WN, INIT_WN}) $display("FAIL read_bank_unchanged: got %h expected %h", MMPathMetric, {INIT_WN, INIT_WN});
    else passCount++;
    @(negedge Clock2);
    MMBlockSelect = 1'b1;
`ifdef MM_REG_READ_EN
    #1;
    checkCount++;
    if (MMPathMetric !== {INIT_WN, INIT_WN}) $display("FAIL reg_read_latency: got %h expected %h", MMPathMetric, {INIT_WN, INIT_WN});
    else passCount++;
`endif
    settleRead;
    checkCount++;
    if (MMPathMetric !== {48'h123_456_789_ABC, INIT_WN}) $display("FAIL toggle_read: got %h expected %h", MMPathMetric, {48'h123_456_789_ABC, INIT_WN});
    else passCount++;
  endtask

  task automatic test_back_to_back;
    @(negedge Clock2);
    MMBlockSelect = 1'b0;
    MMWriteEnable = 1'b1;
    for (int a = 0; a < 16; a++) begin
      MMWriteAddress = 4'(a);
      MMMetric       = pattern(a);
      @(negedge Clock2);
    end
    MMWriteEnable = 1'b0;
    MMReadAddress = 3'd0;
    settleRead;
    checkCount++;
    if (MMPathMetric !== {INIT_WN, INIT_W0}) $display("FAIL b2b_bank0_intact: got %h expected %h", MMPathMetric, {INIT_WN, INIT_W0});
    else passCount++;
    for (int p = 0; p < 8; p++) begin
      @(negedge Clock2);
      MMBlockSelect = 1'b1;
      MMReadAddress = 3'(p);
      settleRead;
      checkCount++;
      if (MMPathMetric !== {pattern(2 * p + 1), pattern(2 * p)})
        $display("FAIL b2b_pair %0d: got %h expected %h", p, MMPathMetric, {pattern(2 * p + 1), pattern(2 * p)});
      else passCount++;
    end
    @(negedge Clock2);
    MMBlockSelect  = 1'b1;
    MMWriteEnable  = 1'b1;
    MMWriteAddress = 4'd0;
    MMMetric       = 48'hFFF_000_FFF_000;
    @(negedge Clock2);
    MMWriteEnable  = 1'b0;
    MMBlockSelect  = 1'b0;
    MMReadAddress  = 3'd0;
    settleRead;
    checkCount++;
    if (MMPathMetric !== {INIT_WN, 48'hFFF_000_FFF_000}) $display("FAIL sel1_writes_bank0: got %h expected %h", MMPathMetric, {INIT_WN, 48'hFFF_000_FFF_000});
    else passCount++;
  endtask

  task automatic test_restart;
    @(negedge Clock2);
    Restart = 1'b1;
    @(posedge Clock2);
    #1;
    checkCount++;
    if (MMReady !== 1'b0) $display("FAIL restart_ready_drop: got %b expected 0", MMReady);
    else passCount++;
    @(negedge Clock2);
    Restart        = 1'b0;
    MMWriteEnable  = 1'b1;
    MMWriteAddress = 4'd3;
    MMMetric       = 48'hFFF_FFF_FFF_FFF;
    for (int i = 0; i < 15; i++) begin
      @(posedge Clock2);
      #1;
      checkCount++;
      if (MMReady !== 1'b0) $display("FAIL restart_ready_low edge %0d: got %b expected 0", i, MMReady);
      else passCount++;
    end
    @(posedge Clock2);
    #1;
    checkCount++;
    if (MMReady !== 1'b1) $display("FAIL restart_ready_high: got %b expected 1", MMReady);
    else passCount++;
    MMWriteEnable = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge Clock2);
      MMBlockSelect = b[0];
      MMReadAddress = 3'd1;
      settleRead;
      checkCount++;
      if (MMPathMetric[95:48] !== INIT_WN) $display("FAIL init_write_ignored bank %0d: got %h expected %h", b, MMPathMetric[95:48], INIT_WN);
      else passCount++;
    end
    @(negedge Clock2);
    MMBlockSelect = 1'b1;
    MMReadAddress = 3'd2;
    settleRead;
    checkCount++;
    if (MMPathMetric !== {INIT_WN, INIT_WN}) $display("FAIL restart_replaced: got %h expected %h", MMPathMetric, {INIT_WN, INIT_WN});
    else passCount++;
    @(negedge Clock2);
    MMBlockSelect = 1'b0;
    MMReadAddress = 3'd0;
    settleRead;
    checkCount++;
    if (MMPathMetric !== {INIT_WN, INIT_W0}) $display("FAIL restart_word0: got %h expected %h", MMPathMetric, {INIT_WN, INIT_W0});
    else passCount++;
  endtask

  task automatic test_reset_mid_init;
    @(negedge Clock2);
    MMBlockSelect = 1'b1;
    MMReadAddress = 3'd0;
    Restart       = 1'b1;
    @(negedge Clock2);
    Restart = 1'b0;
    repeat (7) @(posedge Clock2);
    @(negedge Clock2);
    Reset = 1'b0;
    #1;
    checkCount++;
    if (MMPathMetric !== 96'd0) $display("FAIL midinit_reset_path: got %h expected 0", MMPathMetric);
    else passCount++;
    checkCount++;
    if (MMReady !== 1'b0) $display("FAIL midinit_reset_ready: got %b expected 0", MMReady);
    else passCount++;
    @(negedge Clock2);
    Reset = 1'b1;
    repeat (15) @(posedge Clock2);
    #1;
    checkCount++;
    if (MMReady !== 1'b0) $display("FAIL midinit_ready_edge15: got %b expected 0", MMReady);
    else passCount++;
    @(posedge Clock2);
    #1;
    checkCount++;
    if (MMReady !== 1'b1) $display("FAIL midinit_ready_edge16: got %b expected 1", MMReady);
    else passCount++;
    @(negedge Clock2);
    MMReadAddress = 3'd7;
    settleRead;
    checkCount++;
    if (MMPathMetric !== {INIT_WN, INIT_WN}) $display("FAIL midinit_last_pair: got %h expected %h", MMPathMetric, {INIT_WN, INIT_WN});
    else passCount++;
  endtask

  initial begin
    passCount      = 0;
    checkCount     = 0;
    Reset          = 1'b0;
    Restart        = 1'b0;
    MMWriteEnable  = 1'b0;
    MMWriteAddress = 4'd0;
    MMMetric       = 48'd0;
    MMReadAddress  = 3'd0;
    MMBlockSelect  = 1'b0;
    test_reset;
    test_pingpong;
    test_back_to_back;
    test_restart;
    test_reset_mid_init;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/metric_memory.md
METRIC_MEMORY -- requirements
Module: metric_memory

Interface
REQ-001 The module SHALL provide the port Clock2, an input, 1 bit wide, which is the single clock; all state changes on its rising edge.
REQ-002 The module SHALL provide the port Reset, an input, 1 bit wide, which is an asynchronous, active-low reset.
REQ-003 The module SHALL provide the port Restart, an input, 1 bit wide, which is a synchronous request to reload the initial path metrics.
REQ-004 The module SHALL provide the port MMWriteEnable, an input, 1 bit wide, which is the write strobe from the ACS side.
REQ-005 The module SHALL provide the port MMWriteAddress, an input, 4 bits wide, which is the write word index 0..15.
REQ-006 The module SHALL provide the port MMMetric, an input, 48 bits wide, which is the write data: four 12-bit state metrics.
REQ-007 The module SHALL provide the port MMReadAddress, an input, 3 bits wide, which is the read pair index 0..7.
REQ-008 The module SHALL provide the port MMBlockSelect, an input, 1 bit wide, which is the ping-pong bank select.
REQ-009 The module SHALL provide the port MMPathMetric, an output, 96 bits wide, which carries the two read words.
REQ-010 The module SHALL provide the port MMReady, an output, 1 bit wide, which is high when initialisation is complete and ACS traffic is accepted.

Function
REQ-011 The storage SHALL be two banks (bank 0 and bank 1) of 16 words x 48 bits, holding 64 state metrics per bank; state 4w+i SHALL occupy bits [12i+11:12i] of word w.
REQ-012 The read bank SHALL be the bank numbered MMBlockSelect, and the write bank SHALL be the bank numbered ~MMBlockSelect, so that a read and a write never access the same bank.
REQ-013 In state RUN, when MMWriteEnable=1, the module SHALL write MMMetric into write-bank word MMWriteAddress on the rising edge of Clock2.
REQ-014 MMPathMetric SHALL equal {readbank[2*MMReadAddress+1], readbank[2*MMReadAddress]}.
REQ-015 Read latency for REQ-014 SHALL be 0 cycles (combinational from storage) unless the macro of REQ-024 is defined.
REQ-016 An MMBlockSelect toggle SHALL take effect for writes on the same edge and for reads immediately; written data SHALL become readable after the toggle.
REQ-017 The FSM SHALL have two states: INIT and RUN. It SHALL hold a 4-bit counter InitCount.
REQ-018 In INIT, on each edge, the module SHALL write word InitCount into both banks with the value 12'h000 for state 0 and 12'h200 for states 1..63; InitCount SHALL then increment.
REQ-019 In INIT, when InitCount=15, the write SHALL complete and the FSM SHALL go to RUN; MMReady SHALL be 1 from the next cycle, giving 16 cycles from entering INIT to MMReady.
REQ-020 In RUN, Restart=1 SHALL move the FSM to INIT with InitCount=0 and MMReady=0 on the next edge. Restart in INIT SHALL reset InitCount to 0.
REQ-021 In INIT, MMWriteEnable SHALL be ignored; reads SHALL stay functional and return current contents.

Reset
REQ-022 Asserting Reset (low) SHALL force: FSM=INIT, InitCount=0, MMReady=0, all storage words=0, MMPathMetric=0 (registered path also 0).
REQ-023 After Reset deasserts, initialisation SHALL start on the first edge. Reset asserted mid-INIT or mid-RUN SHALL abort immediately; no partial write SHALL survive.

Configuration
REQ-024 With macro MM_REG_READ_EN defined, MMPathMetric SHALL be registered on Clock2 (latency 1, sampling MMReadAddress/MMBlockSelect at the edge); without it, MMPathMetric SHALL be combinational (latency 0). All other behaviour SHALL be identical.

Verification
REQ-025 Reset low then high -> MMReady=0 for 16 edges then 1; MMBlockSelect=0, MMReadAddress=0 -> MMPathMetric low 48 bits = 48'h200_200_200_000, high 48 bits = 48'h200_200_200_200.
REQ-026 RUN, MMBlockSelect=0, write MMMetric=48'h123_456_789_ABC to address 5 -> read with MMReadAddress=2, MMBlockSelect=0 unchanged; toggle MMBlockSelect to 1 -> MMPathMetric[95:48]=48'h123_456_789_ABC.
REQ-027 MMWriteEnable=1 during INIT with address 3, data all-ones -> after MMReady, both banks word 3 = 48'h200_200_200_200.
REQ-028 Restart pulse in RUN -> MMReady=0 next edge, returns to 1 after 16 edges; earlier-written data replaced by the initial values.
REQ-029 Reset asserted at InitCount=7 -> MMPathMetric=0 immediately, full 16-cycle INIT after release.
REQ-030 Run both builds, with and without MM_REG_READ_EN, -> the read of REQ-026 appears 1 cycle late with the macro and in the same cycle without it.
